// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared FSM state encoding and default operand width
package shift_add_mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/shift_add_mult_add_rc.sv
// add_rc: W-bit ripple-carry adder, carry-in tied low, carry-out exposed
module add_rc #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);
  logic [W:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign co_o = c[W];
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential shift-and-add unsigned multiplier, one bit per RUN cycle.
// Define SHIFT_ADD_MULT_ZERO_SKIP_EN to finish zero-operand multiplies straight from IDLE.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, mul_q, mul_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d, step;
  logic accept, last, zero, co;
  assign accept = (state_q == IDLE) && start;
  assign last   = cnt_q == CW'(WIDTH - 1);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
  assign zero = (a == '0) || (b == '0);
`else
  assign zero = 1'b0;
`endif
  add_rc #(.W(WIDTH)) u_add (
    .a_i  (acc_q),
    .b_i  (mcand_q & {WIDTH{mul_q[0]}}),
    .sum_o(sum),
    .co_o (co)
  );
  // {carry, sum, multiplier} shifted right by one; the dropped LSB already steered the add
  assign step = {co, sum, mul_q[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = zero ? DONE : RUN;
      RUN:     if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy    = state_q == RUN;
    done    = state_q == DONE;
    product = product_q;
  end
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mul_d     = mul_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      mcand_d = a;
      mul_d   = b;
      acc_d   = '0;
      cnt_d   = '0;
      if (zero) product_d = '0;
    end else if (state_q == RUN) begin
      acc_d = step[2*WIDTH-1:WIDTH];
      mul_d = step[WIDTH-1:0];
      cnt_d = cnt_q + CW'(1);
      if (last) product_d = step;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      mul_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mul_q     <= mul_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
endmodule
